// File: rtl/fm_pkg.sv
// Shared types for the FM demodulator acquisition/tracking sequencer.
package fm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_RETRY   = 3'd4
    } fm_state_e;

    typedef logic signed [31:0] sample_t;

endpackage

// File: rtl/fm_demod_seq_lock_window.sv
// Min/max tracker over fixed windows of fm samples; flags window end and
// whether the spread stayed within the lock threshold.
module fm_lock_window
    import fm_pkg::*;
#(
    parameter int WIN_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] fm,
    input  logic [31:0] thresh,
    output logic        win_done,
    output logic        win_good
);

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    sample_t             min_q, min_d, max_q, max_d, fm_s;
    logic [32:0]         spread;

    always_comb begin
        fm_s  = sample_t'(fm);
        cnt_d = clear ? '0 : cnt_q + WIN_LOG2'(1);
        min_d = min_q;
        max_d = max_q;
        if (cnt_q == '0 || fm_s < min_q) min_d = fm_s;
        if (cnt_q == '0 || fm_s > max_q) max_d = fm_s;
        // 33-bit difference so full-scale extremes cannot wrap
        spread   = {max_d[31], max_d} - {min_d[31], min_d};
        win_done = !clear && (&cnt_q);
        win_good = spread <= {1'b0, thresh};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/fm_demod_seq.sv
// Acquisition/tracking sequencer for the FM demodulator software-PLL:
// flush, acquire with wide gain, track with narrow gain, retry with bias sweep.
module fm_demod_seq
    import fm_pkg::*;
#(
    parameter int WIN_LOG2         = 10,
    parameter int LOCK_WINS        = 4,
    parameter int UNLOCK_WINS      = 2,
    parameter int ACQ_TIMEOUT_WINS = 64,
    parameter int RST_CYCLES       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] cfg_bias,
    input  logic [31:0] cfg_bias_step,
    input  logic [7:0]  cfg_sweep_max,
    input  logic [31:0] cfg_gain_acq,
    input  logic [31:0] cfg_gain_trk,
    input  logic [31:0] cfg_lock_thresh,
    input  logic [31:0] fm,
    output logic        dp_reset,
    output logic        dp_run,
    output logic [31:0] vco_gain,
    output logic [31:0] vco_bias,
    output logic        locked,
    output logic [2:0]  state_o,
    output logic [7:0]  retries
);

    localparam logic [7:0]  FLUSH_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_WINS - 1);
    localparam logic [7:0]  UNLOCK_LAST = 8'(UNLOCK_WINS - 1);
    localparam logic [15:0] TO_LAST     = 16'(ACQ_TIMEOUT_WINS - 1);

    fm_state_e   state_q, state_d;
    logic [7:0]  flush_q, flush_d, good_q, good_d, bad_q, bad_d;
    logic [7:0]  sweep_q, sweep_d, retries_q, retries_d;
    logic [15:0] win_q, win_d;
    logic [31:0] bias_q, bias_d, gain_q, gain_d;
    logic        dp_reset_q, dp_reset_d, dp_run_q, dp_run_d;
    logic        locked_q, locked_d;
    logic [8:0]  idx_inc;
    logic        win_clear, win_done, win_good;

    assign win_clear = (state_q != ST_ACQUIRE) && (state_q != ST_TRACK);

    fm_lock_window #(.WIN_LOG2(WIN_LOG2)) u_win (
        .clk      (clk),
        .reset    (reset),
        .clear    (win_clear),
        .fm       (fm),
        .thresh   (cfg_lock_thresh),
        .win_done (win_done),
        .win_good (win_good)
    );

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        good_d    = good_q;
        bad_d     = bad_q;
        win_d     = win_q;
        sweep_d   = sweep_q;
        retries_d = retries_q;
        bias_d    = bias_q;
        gain_d    = gain_q;
        idx_inc   = {1'b0, sweep_q} + 9'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_FLUSH;
                    bias_d    = cfg_bias;
                    sweep_d   = '0;
                    retries_d = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_LAST) state_d = ST_ACQUIRE;
                else flush_d = flush_q + 8'd1;
            end
            ST_ACQUIRE: begin
                if (win_done) begin
                    win_d  = win_q + 16'd1;
                    good_d = win_good ? good_q + 8'd1 : '0;
                    // lock outranks timeout on the same window end
                    if (win_good && good_q == LOCK_LAST) state_d = ST_TRACK;
                    else if (win_q == TO_LAST) state_d = ST_RETRY;
                end
            end
            ST_TRACK: begin
                if (win_done) begin
                    if (win_good) bad_d = '0;
                    else if (bad_q == UNLOCK_LAST) state_d = ST_RETRY;
                    else bad_d = bad_q + 8'd1;
                end
            end
            ST_RETRY: state_d = ST_FLUSH;
            default:  state_d = ST_IDLE;
        endcase

        if (!enable) state_d = ST_IDLE;

        if (state_d == ST_FLUSH && state_q != ST_FLUSH) begin
            flush_d = '0;
            win_d   = '0;
            good_d  = '0;
            gain_d  = cfg_gain_acq;
        end
        if (state_d == ST_TRACK && state_q != ST_TRACK) begin
            bad_d  = '0;
            gain_d = cfg_gain_trk;
        end
        if (state_d == ST_RETRY && state_q != ST_RETRY) begin
            if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
            if (idx_inc > {1'b0, cfg_sweep_max}) begin
                sweep_d = '0;
                bias_d  = cfg_bias;
            end else begin
                sweep_d = idx_inc[7:0];
                bias_d  = bias_q + cfg_bias_step;
            end
        end

        dp_reset_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
        dp_run_d   = (state_d == ST_ACQUIRE) || (state_d == ST_TRACK);
        locked_d   = (state_d == ST_TRACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            flush_q    <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            win_q      <= '0;
            sweep_q    <= '0;
            retries_q  <= '0;
            bias_q     <= '0;
            gain_q     <= '0;
            dp_reset_q <= 1'b1;
            dp_run_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            win_q      <= win_d;
            sweep_q    <= sweep_d;
            retries_q  <= retries_d;
            bias_q     <= bias_d;
            gain_q     <= gain_d;
            dp_reset_q <= dp_reset_d;
            dp_run_q   <= dp_run_d;
            locked_q   <= locked_d;
        end
    end

    assign dp_reset = dp_reset_q;
    assign dp_run   = dp_run_q;
    assign vco_gain = gain_q;
    assign vco_bias = bias_q;
    assign locked   = locked_q;
    assign state_o  = state_q;
    assign retries  = retries_q;

endmodule

// File: tb/tb_fm_demod_seq.sv
// Bench for fm_demod_seq: vector table for window spread limits, directed
// sequences for lock/unlock/sweep/enable/reset, and a randomized window-level model.
module tb_fm_demod_seq;

    localparam int WL = 5;
    localparam int W  = 1 << WL;
    localparam int LW = 4;
    localparam int UW = 2;
    localparam int TO = 8;
    localparam int RC = 4;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_FLUSH = 32'd1;
    localparam logic [31:0] S_ACQ   = 32'd2;
    localparam logic [31:0] S_TRACK = 32'd3;
    localparam logic [31:0] S_RETRY = 32'd4;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] cfg_bias = '0, cfg_bias_step = '0;
    logic [7:0]  cfg_sweep_max = '0;
    logic [31:0] cfg_gain_acq = '0, cfg_gain_trk = '0;
    logic [31:0] cfg_lock_thresh = '0, fm = '0;
    logic        dp_reset, dp_run, locked;
    logic [31:0] vco_gain, vco_bias;
    logic [2:0]  state_o;
    logic [7:0]  retries;

    int checks = 0;
    int failures = 0;

    fm_demod_seq #(
        .WIN_LOG2(WL), .LOCK_WINS(LW), .UNLOCK_WINS(UW),
        .ACQ_TIMEOUT_WINS(TO), .RST_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_bias(cfg_bias), .cfg_bias_step(cfg_bias_step),
        .cfg_sweep_max(cfg_sweep_max), .cfg_gain_acq(cfg_gain_acq),
        .cfg_gain_trk(cfg_gain_trk), .cfg_lock_thresh(cfg_lock_thresh),
        .fm(fm), .dp_reset(dp_reset), .dp_run(dp_run),
        .vco_gain(vco_gain), .vco_bias(vco_bias), .locked(locked),
        .state_o(state_o), .retries(retries)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] th;
        logic        good;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string name, input logic [31:0] st, input logic lk);
        chk({name, "_state"}, 32'(state_o), st);
        chk({name, "_locked"}, 32'(locked), 32'(lk));
    endtask

    // Called on the first FLUSH cycle; walks the reset pulse into ACQUIRE.
    task automatic flush_to_acq(input string tag);
        chk_st({tag, "_fl0"}, S_FLUSH, 1'b0);
        chk({tag, "_fl_dpreset"}, 32'(dp_reset), 32'd1);
        chk({tag, "_fl_dprun"}, 32'(dp_run), 32'd0);
        chk({tag, "_fl_gain"}, vco_gain, cfg_gain_acq);
        for (int i = 1; i < RC; i++) begin
            tick();
            chk({tag, "_fl_hold"}, 32'(dp_reset), 32'd1);
        end
        tick();
        chk_st({tag, "_acq"}, S_ACQ, 1'b0);
        chk({tag, "_acq_dpreset"}, 32'(dp_reset), 32'd0);
        chk({tag, "_acq_dprun"}, 32'(dp_run), 32'd1);
    endtask

    task automatic start(input string tag);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        flush_to_acq(tag);
    endtask

    // pat 0: lo everywhere except hi on the last cycle; pat 1: lo/hi alternating
    task automatic run_window(input logic [31:0] lo, input logic [31:0] hi, input int pat);
        for (int c = 0; c < W; c++) begin
            if (pat == 0) fm = (c == W - 1) ? hi : lo;
            else fm = (c % 2 == 1) ? hi : lo;
            tick();
        end
    endtask

    task automatic rand_window(input longint th, output bit good);
        longint base, span, v, lo, hi;
        bit ext;
        ext  = ($urandom_range(0, 7) == 0);
        span = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 32'(th)))
                                           : longint'($urandom_range(32'(th) + 1, 32'(3 * th)));
        base = longint'($signed($urandom));
        if (base + span > MAXV) base = MAXV - span;
        lo = MAXV;
        hi = MINV;
        for (int c = 0; c < W; c++) begin
            if (ext) v = (c % 2 == 1) ? MAXV : MINV;
            else v = base + longint'($urandom_range(0, 32'(span)));
            fm = v[31:0];
            if (v < lo) lo = v;
            if (v > hi) hi = v;
            tick();
        end
        good = (hi - lo) <= th;
    endtask

    task automatic rand_episode(input int nwin);
        longint th;
        bit good, retry, trk;
        int acq_wins, good_run, bad_run, idx, exp_ret;
        logic [31:0] exp_bias;
        th              = longint'($urandom_range(1, 100000));
        cfg_lock_thresh = 32'(th);
        cfg_bias        = $urandom;
        cfg_bias_step   = $urandom;
        cfg_sweep_max   = 8'($urandom_range(0, 3));
        cfg_gain_acq    = $urandom;
        cfg_gain_trk    = $urandom;
        start("rnd");
        chk("rnd_bias0", vco_bias, cfg_bias);
        idx = 0; exp_ret = 0; trk = 0;
        acq_wins = 0; good_run = 0; bad_run = 0;
        for (int n = 0; n < nwin; n++) begin
            rand_window(th, good);
            retry = 0;
            if (!trk) begin
                acq_wins++;
                good_run = good ? good_run + 1 : 0;
                if (good_run == LW) begin
                    trk = 1;
                    bad_run = 0;
                    chk_st("rnd_lock", S_TRACK, 1'b1);
                    chk("rnd_gain_trk", vco_gain, cfg_gain_trk);
                end else if (acq_wins == TO) retry = 1;
                else chk_st("rnd_acq", S_ACQ, 1'b0);
            end else begin
                bad_run = good ? 0 : bad_run + 1;
                if (bad_run == UW) retry = 1;
                else chk_st("rnd_trk", S_TRACK, 1'b1);
            end
            if (retry) begin
                if (exp_ret < 255) exp_ret++;
                idx = (idx + 1 > int'(cfg_sweep_max)) ? 0 : idx + 1;
                exp_bias = cfg_bias + 32'(idx) * cfg_bias_step;
                chk_st("rnd_retry", S_RETRY, 1'b0);
                chk("rnd_retries", 32'(retries), 32'(exp_ret));
                chk("rnd_bias", vco_bias, exp_bias);
                tick();
                flush_to_acq("rnd_re");
                trk = 0; acq_wins = 0; good_run = 0;
            end
        end
    endtask

    logic [31:0] sweep_exp[4];

    initial begin
        vt[0] = '{32'd1000,     32'd1000,     32'd16,       1'b1};
        vt[1] = '{32'd0,        32'd16,       32'd16,       1'b1};
        vt[2] = '{32'd0,        32'd17,       32'd16,       1'b0};
        vt[3] = '{32'hFFFFFFF8, 32'd8,        32'd16,       1'b1};
        vt[4] = '{32'hFFFFFFF7, 32'd8,        32'd16,       1'b0};
        vt[5] = '{32'hFFFFEC78, 32'd5000,     32'd10000,    1'b1};
        vt[6] = '{32'hFFFFEC78, 32'd5000,     32'd9999,     1'b0};
        vt[7] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1};
        vt[8] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0};
        vt[9] = '{32'h7FFFFFFF, 32'h80000000, 32'd16,       1'b0};
        sweep_exp[0] = 32'h1100;
        sweep_exp[1] = 32'h1200;
        sweep_exp[2] = 32'h1000;
        sweep_exp[3] = 32'h1100;

        #1 reset = 1'b1;
        #1;
        chk_st("rst0", S_IDLE, 1'b0);
        chk("rst0_dpreset", 32'(dp_reset), 32'd1);
        chk("rst0_dprun", 32'(dp_run), 32'd0);
        chk("rst0_gain", vco_gain, 32'd0);
        chk("rst0_bias", vco_bias, 32'd0);
        chk("rst0_retries", 32'(retries), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk_st("idle", S_IDLE, 1'b0);

        // lock acquisition: exact timing
        cfg_gain_acq    = 32'h11111111;
        cfg_gain_trk    = 32'h22222222;
        cfg_lock_thresh = 32'd16;
        cfg_bias        = 32'h1000;
        cfg_bias_step   = 32'h100;
        cfg_sweep_max   = 8'd2;
        start("lk");
        chk("lk_bias", vco_bias, 32'h1000);
        fm = 32'd1000;
        repeat (LW * W - 1) tick();
        chk_st("lk_early", S_ACQ, 1'b0);
        tick();
        chk_st("lk_on", S_TRACK, 1'b1);
        chk("lk_gain", vco_gain, 32'h22222222);

        // loss of lock
        run_window(32'hFFFFEC78, 32'd5000, 1);
        chk_st("ul_one", S_TRACK, 1'b1);
        run_window(32'hFFFFEC78, 32'd5000, 1);
        chk_st("ul_retry", S_RETRY, 1'b0);
        chk("ul_retries", 32'(retries), 32'd1);
        chk("ul_bias", vco_bias, 32'h1100);
        tick();
        flush_to_acq("ul");

        // relock, then drop enable in TRACK
        for (int w = 0; w < LW; w++) run_window(32'd1000, 32'd1000, 0);
        chk_st("rl_on", S_TRACK, 1'b1);
        enable = 1'b0;
        tick();
        chk_st("en_trk", S_IDLE, 1'b0);
        chk("en_trk_dprun", 32'(dp_run), 32'd0);
        chk("en_trk_dpreset", 32'(dp_reset), 32'd1);
        enable = 1'b1;
        tick();
        chk("en_ret_clr", 32'(retries), 32'd0);
        chk("en_bias", vco_bias, 32'h1000);
        flush_to_acq("en");
        for (int w = 0; w < LW; w++) run_window(32'd1000, 32'd1000, 0);
        chk_st("rs_on", S_TRACK, 1'b1);

        // async reset mid-TRACK
        reset = 1'b1;
        enable = 1'b0;
        #1;
        chk_st("rs_mid", S_IDLE, 1'b0);
        chk("rs_mid_dpreset", 32'(dp_reset), 32'd1);
        chk("rs_mid_dprun", 32'(dp_run), 32'd0);
        chk("rs_mid_gain", vco_gain, 32'd0);
        chk("rs_mid_bias", vco_bias, 32'd0);
        tick();
        reset = 1'b0;

        // bias sweep on repeated timeouts
        start("sw");
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < TO - 1; w++) run_window(32'hFFFFEC78, 32'd5000, 1);
            chk_st("sw_wait", S_ACQ, 1'b0);
            run_window(32'hFFFFEC78, 32'd5000, 1);
            chk_st("sw_retry", S_RETRY, 1'b0);
            chk("sw_bias", vco_bias, sweep_exp[k]);
            chk("sw_retries", 32'(retries), 32'(k + 1));
            tick();
            if (k < 3) flush_to_acq("sw");
        end
        chk_st("ef_fl", S_FLUSH, 1'b0);
        enable = 1'b0;
        tick();
        chk_st("ef_idle", S_IDLE, 1'b0);
        chk("ef_dprun", 32'(dp_run), 32'd0);
        chk("ef_dpreset", 32'(dp_reset), 32'd1);

        // sweep_max zero keeps the nominal bias
        cfg_sweep_max = 8'd0;
        start("sz");
        for (int w = 0; w < TO; w++) run_window(32'd0, 32'd5000, 1);
        chk_st("sz_retry", S_RETRY, 1'b0);
        chk("sz_bias", vco_bias, 32'h1000);
        chk("sz_retries", 32'(retries), 32'd1);

        // spread limit vectors
        for (int i = 0; i < 10; i++) begin
            cfg_lock_thresh = vt[i].th;
            start("vec");
            for (int w = 0; w < LW; w++) run_window(vt[i].lo, vt[i].hi, 0);
            chk_st($sformatf("vec%0d", i), vt[i].good ? S_TRACK : S_ACQ, vt[i].good);
        end

        for (int e = 0; e < 3; e++) rand_episode(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
